dat_transfer_ctrl: RTL and testbench
====================================

# dat_transfer_ctrl

Parametrised next-generation DAT-line transfer controller for the SD host. It sits between the Wishbone-side host registers, the DAT physical layer and the FIFO controller, and sequences single- or multi-block transfers. Over the previous controller it adds a configurable block counter, a 1/4-bit bus-width mode, per-block CRC status with bounded retry, a watchdog timeout, host abort, and an error report.

## Interface
Parameters:
- BLK_CNT_W, 8, width of block count / remaining-block counter
- TIMEOUT_W, 16, width of watchdog counter
- TIMEOUT_CYCLES, 50000, cycles allowed in any waiting state before timeout (must be < 2^TIMEOUT_W)
- MAX_RETRY, 2, re-sends allowed per block after CRC failure

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- new_dat  in  1  host start request, sampled only in IDLE
- write_read  in  1  1 = write to card, 0 = read
- block_count  in  BLK_CNT_W  blocks requested
- multiple_data  in  1  multi-block mode
- wide_bus  in  1  1 = 4-bit DAT, 0 = 1-bit
- abort  in  1  host abort
- serial_ready  in  1  phys layer ready for new transfer
- complete  in  1  phys layer finished current block (1-cycle pulse)
- crc_ok  in  1  CRC status of block, valid with complete
- ack_in  in  1  phys layer acknowledges end of transfer
- fifo_okay  in  1  FIFO holds (write) / has room for (read) one block
- idle_out  out  1  controller in IDLE
- strobe_out  out  1  phys layer: transfer current block
- ack_out  out  1  end-of-transfer handshake to phys layer
- writereadphys  out  1  latched direction
- multiple  out  1  latched multi-block flag
- bus_width  out  1  latched wide_bus
- blocks_left  out  BLK_CNT_W  blocks still to transfer
- transfer_complete  out  1  1-cycle success pulse
- transfer_error  out  1  1-cycle failure pulse
- error_code  out  2  00 none, 01 CRC retries exhausted, 10 timeout, 11 abort

## Operation
- States: IDLE, SETUP, CHECK_FIFO, TRANSMIT, ACK, DONE, ERROR. Outputs are Moore, decoded from state and internal registers only; no input-to-output combinational path.
- Reset: state IDLE; idle_out=1; all other outputs 0; blocks_left, retry and watchdog counters 0.
- IDLE: on new_dat=1, latch write_read, multiple_data, wide_bus; blocks_left = 1 if multiple_data=0 or block_count=0, else block_count; clear error_code, retry counter; go SETUP. new_dat ignored in all other states.
- SETUP: serial_ready=1 -> CHECK_FIFO.
- CHECK_FIFO: fifo_okay=1 -> TRANSMIT.
- TRANSMIT: strobe_out=1. On complete: crc_ok=1 -> blocks_left-1, retry=0; then ACK if result is 0, else CHECK_FIFO. crc_ok=0 -> if retry<MAX_RETRY then retry+1, CHECK_FIFO (same block, blocks_left unchanged); else ERROR with code 01.
- ACK: ack_out=1; ack_in=1 -> DONE.
- DONE: transfer_complete=1 for one cycle -> IDLE.
- ERROR: transfer_error=1 for one cycle -> IDLE; error_code holds until next accepted new_dat.
- Watchdog: clears on every state change; counts in SETUP, CHECK_FIFO, TRANSMIT, ACK; reaching TIMEOUT_CYCLES-1 without exit -> ERROR, code 10.
- Priority per cycle: reset > abort (any state except IDLE/DONE/ERROR -> ERROR, code 11) > normal exit condition > timeout.
- writereadphys, multiple, bus_width hold latched values from SETUP until IDLE is re-entered, where they return to 0.

## Timing
- new_dat high at edge N -> SETUP at N+1; strobe_out earliest at N+3 (serial_ready, fifo_okay already high).
- complete with last good block at edge M -> ack_out at M+1; ack_in at edge K -> transfer_complete high during K+1..K+2 window (one cycle), idle_out at K+2.
- Between blocks, strobe_out drops for at least one cycle (CHECK_FIFO).
- Reset asserted mid-transfer: next edge IDLE, all outputs at reset values; no completion/error pulse.
- blocks_left never wraps: decrement only when non-zero.

## Test plan
- Single write, block_count=5, multiple_data=0 -> blocks_left=1, one strobe period, transfer_complete pulse, error_code=00.
- Multi read, block_count=3, crc_ok always 1 -> three strobe periods separated by CHECK_FIFO, blocks_left 3->2->1->0, one transfer_complete.
- Multi write block_count=2, MAX_RETRY=2, first block crc_ok=0 twice then 1 -> blocks_left stays 2 for three strobes, then completes; crc_ok=0 three times -> transfer_error, error_code=01.
- fifo_okay held 0, TIMEOUT_CYCLES=16 -> ERROR exactly 16 cycles after CHECK_FIFO entry, error_code=10, idle_out next cycle.
- abort in TRANSMIT simultaneous with complete -> ERROR, code 11, no transfer_complete; following new_dat clears code to 00.
- reset asserted in ACK -> next cycle idle_out=1, ack_out=0, blocks_left=0, no pulse.

Source files
------------

// File: rtl/dat_transfer_ctrl.sv
// SD DAT-line transfer sequencer: walks single/multi-block transfers through setup, FIFO check, strobe, ack.
// Moore outputs, one cycle per state step; stalls on serial_ready/fifo_okay/complete/ack_in under a shared watchdog.
module dat_transfer_ctrl #(
  parameter int BLK_CNT_W      = 8,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRY      = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 new_dat,
  input  logic                 write_read,
  input  logic [BLK_CNT_W-1:0] block_count,
  input  logic                 multiple_data,
  input  logic                 wide_bus,
  input  logic                 abort,
  input  logic                 serial_ready,
  input  logic                 complete,
  input  logic                 crc_ok,
  input  logic                 ack_in,
  input  logic                 fifo_okay,
  output logic                 idle_out,
  output logic                 strobe_out,
  output logic                 ack_out,
  output logic                 writereadphys,
  output logic                 multiple,
  output logic                 bus_width,
  output logic [BLK_CNT_W-1:0] blocks_left,
  output logic                 transfer_complete,
  output logic                 transfer_error,
  output logic [1:0]           error_code
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0]   RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [TIMEOUT_W-1:0] WD_LIM    = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CRC     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    IDLE, SETUP, CHECK_FIFO, TRANSMIT, ACK, DONE, ERROR
  } state_t;

  state_t                 state, state_nxt;
  logic [TIMEOUT_W-1:0]   wdog, wdog_nxt;
  logic [RETRY_W-1:0]     retry, retry_nxt;
  logic [BLK_CNT_W-1:0]   blocks_nxt, blocks_dec;
  logic [1:0]             code_nxt;
  logic                   dir_nxt, mult_nxt, width_nxt;
  logic                   waiting, timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      wdog          <= '0;
      retry         <= '0;
      blocks_left   <= '0;
      error_code    <= ERR_NONE;
      writereadphys <= 1'b0;
      multiple      <= 1'b0;
      bus_width     <= 1'b0;
    end else begin
      state         <= state_nxt;
      wdog          <= wdog_nxt;
      retry         <= retry_nxt;
      blocks_left   <= blocks_nxt;
      error_code    <= code_nxt;
      writereadphys <= dir_nxt;
      multiple      <= mult_nxt;
      bus_width     <= width_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    blocks_nxt        = blocks_left;
    retry_nxt         = retry;
    code_nxt          = error_code;
    dir_nxt           = writereadphys;
    mult_nxt          = multiple;
    width_nxt         = bus_width;
    idle_out          = 1'b0;
    strobe_out        = 1'b0;
    ack_out           = 1'b0;
    transfer_complete = 1'b0;
    transfer_error    = 1'b0;
    waiting    = (state == SETUP) || (state == CHECK_FIFO) ||
                 (state == TRANSMIT) || (state == ACK);
    timeout    = (wdog == WD_LIM);
    // Saturating decrement: the counter never wraps below zero.
    blocks_dec = (blocks_left != '0) ? blocks_left - 1'b1 : blocks_left;

    case (state)
      IDLE: begin
        idle_out = 1'b1;
        if (new_dat) begin
          dir_nxt    = write_read;
          mult_nxt   = multiple_data;
          width_nxt  = wide_bus;
          blocks_nxt = (!multiple_data || block_count == '0) ? BLK_CNT_W'(1) : block_count;
          code_nxt   = ERR_NONE;
          retry_nxt  = '0;
          state_nxt  = SETUP;
        end
      end
      SETUP: if (serial_ready) state_nxt = CHECK_FIFO;
      CHECK_FIFO: if (fifo_okay) state_nxt = TRANSMIT;
      TRANSMIT: begin
        strobe_out = 1'b1;
        if (complete) begin
          if (crc_ok) begin
            blocks_nxt = blocks_dec;
            retry_nxt  = '0;
            state_nxt  = (blocks_dec == '0) ? ACK : CHECK_FIFO;
          end else if (retry < RETRY_LIM) begin
            retry_nxt = retry + 1'b1;
            state_nxt = CHECK_FIFO;
          end else begin
            code_nxt  = ERR_CRC;
            state_nxt = ERROR;
          end
        end
      end
      ACK: begin
        ack_out = 1'b1;
        if (ack_in) state_nxt = DONE;
      end
      DONE: begin
        transfer_complete = 1'b1;
        state_nxt         = IDLE;
        dir_nxt           = 1'b0;
        mult_nxt          = 1'b0;
        width_nxt         = 1'b0;
      end
      ERROR: begin
        transfer_error = 1'b1;
        state_nxt      = IDLE;
        dir_nxt        = 1'b0;
        mult_nxt       = 1'b0;
        width_nxt      = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides whatever the waiting state decided; timeout only fires if nothing else moved us.
    if (waiting) begin
      if (abort) begin
        state_nxt  = ERROR;
        code_nxt   = ERR_ABORT;
        blocks_nxt = blocks_left;
        retry_nxt  = retry;
      end else if (state_nxt == state && timeout) begin
        state_nxt = ERROR;
        code_nxt  = ERR_TIMEOUT;
      end
    end

    wdog_nxt = (waiting && state_nxt == state) ? wdog + 1'b1 : '0;
  end

endmodule

// File: tb/tb_dat_transfer_ctrl.sv
// Bench for dat_transfer_ctrl: a phys-layer responder plus a per-transfer outcome model.
module tb_dat_transfer_ctrl;
  localparam int BLK_CNT_W      = 8;
  localparam int TIMEOUT_W      = 16;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int MAX_RETRY      = 2;

  logic clock = 1'b0;
  logic reset, new_dat, write_read, multiple_data, wide_bus, abort;
  logic serial_ready, complete, crc_ok, ack_in, fifo_okay;
  logic [BLK_CNT_W-1:0] block_count, blocks_left;
  logic idle_out, strobe_out, ack_out, writereadphys, multiple, bus_width;
  logic transfer_complete, transfer_error;
  logic [1:0] error_code;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  dat_transfer_ctrl #(
    .BLK_CNT_W(BLK_CNT_W), .TIMEOUT_W(TIMEOUT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clock(clock), .reset(reset), .new_dat(new_dat), .write_read(write_read),
    .block_count(block_count), .multiple_data(multiple_data), .wide_bus(wide_bus),
    .abort(abort), .serial_ready(serial_ready), .complete(complete), .crc_ok(crc_ok),
    .ack_in(ack_in), .fifo_okay(fifo_okay), .idle_out(idle_out), .strobe_out(strobe_out),
    .ack_out(ack_out), .writereadphys(writereadphys), .multiple(multiple),
    .bus_width(bus_width), .blocks_left(blocks_left),
    .transfer_complete(transfer_complete), .transfer_error(transfer_error),
    .error_code(error_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic coin();
    return $urandom_range(0, 3) != 0;
  endfunction

  // One host transfer. plan[i] is the CRC result the phys layer reports for the i-th strobe;
  // abort_at (>=0) raises abort together with complete on that strobe.
  task automatic do_xfer(input logic wr, input logic [7:0] cnt, input logic multi, input logic wide,
                         input logic [63:0] plan, input int abort_at, input logic fast);
    int nb, rem, rty, n_str, s, dly, first_str;
    logic [7:0] exp_bl [$];
    logic exp_ok, prev_str, after_cmp, last_good, ack_drv, finished;
    logic [1:0] exp_code;

    nb = (multi && cnt != 8'd0) ? int'(cnt) : 1;
    rem = nb; rty = 0; n_str = 0; exp_ok = 1'b0; exp_code = 2'b00;
    for (int i = 0; i < 64; i++) begin
      exp_bl.push_back(8'(rem));
      n_str++;
      if (i == abort_at) begin exp_code = 2'b11; break; end
      if (plan[i]) begin
        rem--; rty = 0;
        if (rem == 0) begin exp_ok = 1'b1; break; end
      end else if (rty < MAX_RETRY) rty++;
      else begin exp_code = 2'b01; break; end
    end

    @(negedge clock);
    new_dat = 1'b1; write_read = wr; multiple_data = multi; wide_bus = wide; block_count = cnt;
    serial_ready = fast | coin(); fifo_okay = fast | coin();
    @(negedge clock);
    new_dat = 1'b0; write_read = ~wr; multiple_data = ~multi; wide_bus = ~wide;
    block_count = 8'($urandom);
    check("accept_busy", 32'(idle_out), 32'd0);
    check("accept_code", 32'(error_code), 32'd0);
    check("accept_blocks", 32'(blocks_left), 32'(nb));
    check("latch_dir", 32'(writereadphys), 32'(wr));
    check("latch_multi", 32'(multiple), 32'(multi));
    check("latch_width", 32'(bus_width), 32'(wide));

    s = -1; dly = 0; first_str = -1;
    prev_str = 1'b0; after_cmp = 1'b0; last_good = 1'b0; ack_drv = 1'b0; finished = 1'b0;
    for (int cyc = 1; cyc <= 1500 && !finished; cyc++) begin
      if (ack_drv) check("ack_to_done", 32'(transfer_complete), 32'd1);
      if (after_cmp) begin
        check("strobe_gap", 32'(strobe_out), 32'd0);
        if (last_good) check("ack_after_last", 32'(ack_out), 32'd1);
      end
      if (strobe_out && !prev_str) begin
        s++;
        if (first_str < 0) first_str = cyc;
        dly = int'($urandom_range(0, 3));
        if (s < n_str) check("blocks_left", 32'(blocks_left), 32'(exp_bl[s]));
        check("strobe_dir", 32'(writereadphys), 32'(wr));
        check("strobe_width", 32'(bus_width), 32'(wide));
      end
      prev_str = strobe_out;
      finished = transfer_complete | transfer_error;
      complete = 1'b0; crc_ok = 1'b0; abort = 1'b0; ack_in = 1'b0;
      ack_drv = 1'b0; after_cmp = 1'b0; last_good = 1'b0;
      if (!finished) begin
        if (strobe_out) begin
          if (dly == 0) begin
            complete  = 1'b1;
            crc_ok    = (s >= 0 && s < 64) ? plan[s] : 1'b1;
            abort     = (s == abort_at);
            after_cmp = (s != abort_at);
            last_good = exp_ok && (s == n_str - 1);
          end else dly--;
        end
        if (ack_out && coin()) begin ack_in = 1'b1; ack_drv = 1'b1; end
        serial_ready = fast | coin(); fifo_okay = fast | coin();
        @(negedge clock);
      end
    end

    check("xfer_end", 32'(finished), 32'd1);
    check("done_pulse", 32'(transfer_complete), 32'(exp_ok));
    check("err_pulse", 32'(transfer_error), 32'(!exp_ok));
    check("err_code", 32'(error_code), 32'(exp_code));
    check("strobe_count", 32'(s + 1), 32'(n_str));
    if (fast) check("first_strobe_latency", 32'(first_str), 32'd3);
    serial_ready = 1'b0; fifo_okay = 1'b0;
    @(negedge clock);
    check("back_idle", 32'(idle_out), 32'd1);
    check("pulse_width", 32'(transfer_complete | transfer_error), 32'd0);
    check("code_hold", 32'(error_code), 32'(exp_code));
    check("unlatch", 32'({writereadphys, multiple, bus_width}), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL sim_time_limit: observed no end, expected finish");
    $fatal(1, "simulation stuck");
  end

  initial begin
    logic got;
    int hit;
    reset = 1'b1; new_dat = 1'b0; write_read = 1'b0; multiple_data = 1'b0; wide_bus = 1'b0;
    abort = 1'b0; serial_ready = 1'b0; complete = 1'b0; crc_ok = 1'b0; ack_in = 1'b0;
    fifo_okay = 1'b0; block_count = '0;
    repeat (3) @(negedge clock);
    check("rst_idle", 32'(idle_out), 32'd1);
    check("rst_outs", 32'({strobe_out, ack_out, writereadphys, multiple, bus_width,
                            transfer_complete, transfer_error}), 32'd0);
    check("rst_blocks", 32'(blocks_left), 32'd0);
    check("rst_code", 32'(error_code), 32'd0);
    reset = 1'b0;

    do_xfer(1'b1, 8'd5, 1'b0, 1'b0, '1, -1, 1'b1);      // single write
    do_xfer(1'b0, 8'd3, 1'b1, 1'b1, '1, -1, 1'b1);      // multi read, all good
    do_xfer(1'b1, 8'd2, 1'b1, 1'b0, 64'hC, -1, 1'b0);   // two CRC retries then good
    do_xfer(1'b1, 8'd2, 1'b1, 1'b1, 64'h0, -1, 1'b1);   // retries exhausted
    do_xfer(1'b0, 8'd3, 1'b1, 1'b0, '1, 0, 1'b1);       // abort together with complete
    do_xfer(1'b1, 8'd0, 1'b1, 1'b1, '1, -1, 1'b1);      // zero count in multi mode -> one block

    // Watchdog: FIFO never ready; ERROR lands 16 cycles after CHECK_FIFO entry.
    @(negedge clock);
    new_dat = 1'b1; multiple_data = 1'b0; serial_ready = 1'b1; fifo_okay = 1'b0;
    @(negedge clock);
    new_dat = 1'b0;
    hit = 0;
    for (int c = 1; c <= 40 && hit == 0; c++) begin
      if (transfer_error) hit = c;
      else @(negedge clock);
    end
    check("timeout_cycle", 32'(hit), 32'd18);
    check("timeout_code", 32'(error_code), 32'd2);
    serial_ready = 1'b0;
    @(negedge clock);
    check("timeout_idle", 32'(idle_out), 32'd1);

    // Reset while waiting in ACK.
    @(negedge clock);
    new_dat = 1'b1; multiple_data = 1'b1; block_count = 8'd1; write_read = 1'b1;
    serial_ready = 1'b1; fifo_okay = 1'b1; ack_in = 1'b0;
    @(negedge clock);
    new_dat = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (strobe_out) got = 1'b1;
      else @(negedge clock);
    end
    check("rst_strobe_seen", 32'(got), 32'd1);
    complete = 1'b1; crc_ok = 1'b1;
    @(negedge clock);
    complete = 1'b0; crc_ok = 1'b0;
    check("rst_in_ack", 32'(ack_out), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; serial_ready = 1'b0; fifo_okay = 1'b0;
    check("rst_ack_idle", 32'(idle_out), 32'd1);
    check("rst_ack_outs", 32'({ack_out, strobe_out, writereadphys, transfer_complete,
                                transfer_error}), 32'd0);
    check("rst_ack_blocks", 32'(blocks_left), 32'd0);
    repeat (3) begin
      @(negedge clock);
      check("rst_no_pulse", 32'({idle_out, transfer_complete, transfer_error}), 32'b100);
    end

    for (int t = 0; t < 30; t++) begin
      logic [63:0] p;
      int ab;
      p  = {$urandom(), $urandom()} | {$urandom(), $urandom()};
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
      do_xfer(1'($urandom), 8'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), p, ab,
              1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
